// File: rtl/mem_access.sv
// mem_access: RISC-V memory-access stage; performs loads/stores as byte transfers to the memory controller.
// Optional build macro MEM_MISALIGN_CHECK_EN rejects misaligned halfword/word ops with a misalign_o pulse.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_dout_o,
    input  logic [7:0]  mem_din_i,
    input  logic        mem_ack_i,
    output logic        stall_req_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] EX_LB   = 8'h20;
    localparam logic [7:0] EX_LH   = 8'h21;
    localparam logic [7:0] EX_LW   = 8'h22;
    localparam logic [7:0] EX_LBU  = 8'h24;
    localparam logic [7:0] EX_LHU  = 8'h25;
    localparam logic [7:0] EX_SB   = 8'h28;
    localparam logic [7:0] EX_SH   = 8'h29;
    localparam logic [7:0] EX_SW   = 8'h2B;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_op;
    logic [31:0]     r_addr;
    logic [3:0][7:0] r_data;
    logic [4:0]      r_wd;
    logic            r_wreg;
    logic [1:0]      r_cnt;
    logic [3:0][7:0] r_buf;

    logic [4:0]      r_out_wd;
    logic            r_out_wreg;
    logic [31:0]     r_out_wdata;

    logic            w_in_mem;
    logic            w_in_misalign;
    logic            w_op_store;
    logic [1:0]      w_last_idx;
    logic            w_last_ack;
    logic [3:0][7:0] w_buf_merged;
    logic [31:0]     w_load_result;

    always_comb begin
        w_in_mem = 1'b0;
        case (aluop_i)
            EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU,
            EX_SB, EX_SH, EX_SW: w_in_mem = 1'b1;
            default:             w_in_mem = 1'b0;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        w_in_misalign = 1'b0;
        case (aluop_i)
            EX_LH, EX_LHU, EX_SH: w_in_misalign = addr_i[0];
            EX_LW, EX_SW:         w_in_misalign = (addr_i[1:0] != 2'b00);
            default:              w_in_misalign = 1'b0;
        endcase
    end
`else
    assign w_in_misalign = 1'b0;
`endif

    // Decode of the latched op: index of the final byte and transfer direction.
    always_comb begin
        w_last_idx = 2'd0;
        w_op_store = 1'b0;
        case (r_op)
            EX_LH, EX_LHU: w_last_idx = 2'd1;
            EX_LW:         w_last_idx = 2'd3;
            EX_SB:         w_op_store = 1'b1;
            EX_SH: begin
                w_last_idx = 2'd1;
                w_op_store = 1'b1;
            end
            EX_SW: begin
                w_last_idx = 2'd3;
                w_op_store = 1'b1;
            end
            default: begin
                w_last_idx = 2'd0;
                w_op_store = 1'b0;
            end
        endcase
    end

    assign w_last_ack = (r_state == ST_ACCESS) && mem_ack_i && (r_cnt == w_last_idx);

    // The final byte arrives in the completion cycle, so merge it before extending.
    always_comb begin
        w_buf_merged        = r_buf;
        w_buf_merged[r_cnt] = mem_din_i;
    end

    always_comb begin
        w_load_result = 32'd0;
        case (r_op)
            EX_LB:   w_load_result = {{24{w_buf_merged[0][7]}}, w_buf_merged[0]};
            EX_LBU:  w_load_result = {24'd0, w_buf_merged[0]};
            EX_LH:   w_load_result = {{16{w_buf_merged[1][7]}}, w_buf_merged[1], w_buf_merged[0]};
            EX_LHU:  w_load_result = {16'd0, w_buf_merged[1], w_buf_merged[0]};
            EX_LW:   w_load_result = w_buf_merged;
            default: w_load_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall_req_o  = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = 32'd0;
        mem_dout_o   = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_in_mem && !w_in_misalign) begin
                    stall_req_o  = 1'b1;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_req_o   = 1'b1;
                mem_we_o    = w_op_store;
                mem_addr_o  = r_addr + {30'd0, r_cnt};
                mem_dout_o  = r_data[r_cnt];
                // Released in the last-ack cycle so upstream advances on the completion edge.
                stall_req_o = ~w_last_ack;
                if (w_last_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == ST_IDLE) && w_in_mem && w_in_misalign;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= MEM_NOP;
            r_addr      <= 32'd0;
            r_data      <= '0;
            r_wd        <= 5'd0;
            r_wreg      <= 1'b0;
            r_cnt       <= 2'd0;
            r_buf       <= '0;
            r_out_wd    <= 5'd0;
            r_out_wreg  <= 1'b0;
            r_out_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_mem) begin
                        r_op        <= aluop_i;
                        r_addr      <= addr_i;
                        r_data      <= wdata_i;
                        r_wd        <= wd_i;
                        r_wreg      <= wreg_i;
                        r_cnt       <= 2'd0;
                        r_buf       <= '0;
                        r_out_wd    <= 5'd0;
                        r_out_wreg  <= 1'b0;
                        r_out_wdata <= 32'd0;
                    end else begin
                        r_out_wd    <= wd_i;
                        r_out_wreg  <= wreg_i;
                        r_out_wdata <= wdata_i;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack_i) begin
                        r_buf[r_cnt] <= mem_din_i;
                        r_cnt        <= r_cnt + 2'd1;
                    end
                    if (w_last_ack) begin
                        r_out_wd <= r_wd;
                        if (w_op_store) begin
                            r_out_wreg  <= 1'b0;
                            r_out_wdata <= 32'd0;
                        end else begin
                            r_out_wreg  <= r_wreg;
                            r_out_wdata <= w_load_result;
                        end
                    end
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase
        end
    end

    assign wd_o    = r_out_wd;
    assign wreg_o  = r_out_wreg;
    assign wdata_o = r_out_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: responds to byte requests and checks results against a scoreboard queue.
module tb_mem_access;

    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h0C;
    localparam logic [7:0] EX_LB   = 8'h20;
    localparam logic [7:0] EX_LH   = 8'h21;
    localparam logic [7:0] EX_LW   = 8'h22;
    localparam logic [7:0] EX_LBU  = 8'h24;
    localparam logic [7:0] EX_LHU  = 8'h25;
    localparam logic [7:0] EX_SB   = 8'h28;
    localparam logic [7:0] EX_SH   = 8'h29;
    localparam logic [7:0] EX_SW   = 8'h2B;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_dout_o;
    logic [7:0]  mem_din_i;
    logic        mem_ack_i;
    logic        stall_req_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        misalign_o;

    typedef struct {
        logic [31:0] wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic        chk_wd;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_dout_o  (mem_dout_o),
        .mem_din_i   (mem_din_i),
        .mem_ack_i   (mem_ack_i),
        .stall_req_o (stall_req_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_wdata"}, wdata_o, e.wdata);
            chk({tag, "_wreg"}, {31'd0, wreg_o}, {31'd0, e.wreg});
            if (e.chk_wd) chk({tag, "_wd"}, {27'd0, wd_o}, {27'd0, e.wd});
        end
        $display("txn %s: wdata_o=0x%08h wd_o=%0d wreg_o=%0d", tag, wdata_o, wd_o, wreg_o);
    endtask

    // Called at a negedge; returns one cycle later after checking the registered result.
    task automatic do_alu(input string tag, input logic [31:0] data, input logic [4:0] wd, input logic wreg);
        aluop_i = OP_ADD;
        addr_i  = 32'h0000_0FF0;
        wdata_i = data;
        wd_i    = wd;
        wreg_i  = wreg;
        sb_q.push_back('{data, wd, wreg, 1'b1});
        #1;
        chk({tag, "_stall"}, {31'd0, stall_req_o}, 32'd0);
        @(negedge clk);
        #1;
        check_result(tag);
        chk({tag, "_stall_after"}, {31'd0, stall_req_o}, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign_o}, 32'd0);
    endtask

    // Called at a negedge; rbytes holds read bytes little-endian; gap0/gap1 are wait cycles before each ack.
    task automatic do_mem(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] rbytes, input int gap0, input int gap1,
                          input logic [31:0] exp_wdata);
        int   n;
        logic is_store;
        n        = (op == EX_LW || op == EX_SW) ? 4 :
                   (op == EX_LH || op == EX_LHU || op == EX_SH) ? 2 : 1;
        is_store = (op == EX_SB || op == EX_SH || op == EX_SW);
        aluop_i  = op;
        addr_i   = addr;
        wdata_i  = data;
        wd_i     = wd;
        wreg_i   = wreg;
        sb_q.push_back('{exp_wdata, wd, is_store ? 1'b0 : wreg, !is_store});
        #1;
        chk({tag, "_stall_idle"}, {31'd0, stall_req_o}, 32'd1);
        chk({tag, "_req_idle"}, {31'd0, mem_req_o}, 32'd0);
        for (int k = 0; k < n; k++) begin
            int g;
            g = (k == 0) ? gap0 : gap1;
            for (int w = 0; w <= g; w++) begin
                @(negedge clk);
                aluop_i   = MEM_NOP;
                wdata_i   = 32'hDEAD_BEEF;
                wd_i      = 5'd31;
                wreg_i    = 1'b1;
                mem_ack_i = (w == g);
                mem_din_i = rbytes[8*k +: 8];
                #1;
                chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd1);
                chk({tag, "_addr"}, mem_addr_o, addr + 32'(k));
                chk({tag, "_we"}, {31'd0, mem_we_o}, {31'd0, is_store});
                if (is_store) chk({tag, "_dout"}, {24'd0, mem_dout_o}, {24'd0, data[8*k +: 8]});
                chk({tag, "_stall_acc"}, {31'd0, stall_req_o},
                    ((w == g) && (k == n - 1)) ? 32'd0 : 32'd1);
                if (k == 0 && w == 0) begin
                    chk({tag, "_cleared_wreg"}, {31'd0, wreg_o}, 32'd0);
                    chk({tag, "_cleared_wdata"}, wdata_o, 32'd0);
                end
            end
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        wreg_i    = 1'b0;
        #1;
        chk({tag, "_req_done"}, {31'd0, mem_req_o}, 32'd0);
        chk({tag, "_stall_done"}, {31'd0, stall_req_o}, 32'd0);
        check_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        aluop_i   = MEM_NOP;
        addr_i    = 32'd0;
        wdata_i   = 32'd0;
        wd_i      = 5'd0;
        wreg_i    = 1'b0;
        mem_din_i = 8'd0;
        mem_ack_i = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wd", {27'd0, wd_o}, 32'd0);
        chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        do_alu("add", 32'h1234_5678, 5'd5, 1'b1);
        do_mem("lw",  EX_LW,  32'h0000_1000, 32'h0, 5'd7,  1'b1, 32'h1234_5678, 0, 0, 32'h1234_5678);
        do_mem("lb",  EX_LB,  32'h0000_0020, 32'h0, 5'd8,  1'b1, 32'h0000_0080, 0, 0, 32'hFFFF_FF80);
        do_mem("lbu", EX_LBU, 32'h0000_0020, 32'h0, 5'd9,  1'b1, 32'h0000_0080, 0, 0, 32'h0000_0080);
        do_mem("lh_wrap", EX_LH, 32'hFFFF_FFFF, 32'h0, 5'd10, 1'b1, 32'h0000_8001, 0, 0, 32'hFFFF_8001);
        do_mem("lhu", EX_LHU, 32'h0000_0100, 32'h0, 5'd11, 1'b1, 32'h0000_8001, 1, 1, 32'h0000_8001);
        do_mem("sh",  EX_SH,  32'h0000_0040, 32'hAABB_CCDD, 5'd12, 1'b1, 32'h0, 2, 1, 32'h0);
        do_mem("sw",  EX_SW,  32'h0000_0050, 32'h1122_3344, 5'd13, 1'b1, 32'h0, 0, 1, 32'h0);
        do_alu("add2", 32'hCAFE_0001, 5'd14, 1'b1);

`ifdef MEM_MISALIGN_CHECK_EN
        aluop_i = EX_LW;
        addr_i  = 32'h0000_1002;
        wdata_i = 32'h0000_0055;
        wd_i    = 5'd3;
        wreg_i  = 1'b1;
        #1;
        chk("mis_stall", {31'd0, stall_req_o}, 32'd0);
        chk("mis_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        aluop_i = MEM_NOP;
        wreg_i  = 1'b0;
        #1;
        chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
        chk("mis_wreg", {31'd0, wreg_o}, 32'd0);
        chk("mis_wdata", wdata_o, 32'd0);
        chk("mis_req2", {31'd0, mem_req_o}, 32'd0);
        $display("txn misalign: misalign_o=%0d", misalign_o);
        @(negedge clk);
        #1;
        chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
`else
        do_mem("lw_mis", EX_LW, 32'h0000_1002, 32'h0, 5'd3, 1'b1, 32'hA1B2_C3D4, 0, 0, 32'hA1B2_C3D4);
`endif

        // Reset mid-LW after two acks; the aborted access leaves nothing in the scoreboard.
        aluop_i = EX_LW;
        addr_i  = 32'h0000_2000;
        wdata_i = 32'h0;
        wd_i    = 5'd6;
        wreg_i  = 1'b1;
        #1;
        chk("rlw_stall", {31'd0, stall_req_o}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            aluop_i   = MEM_NOP;
            mem_ack_i = 1'b1;
            mem_din_i = 8'hA0 + 8'(k);
            #1;
            chk("rlw_addr", mem_addr_o, 32'h0000_2000 + 32'(k));
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        chk("rlw_req_before", {31'd0, mem_req_o}, 32'd1);
        chk("rlw_addr_before", mem_addr_o, 32'h0000_2002);
        #1;
        rst = 1'b0;
        #1;
        chk("rlw_req_async", {31'd0, mem_req_o}, 32'd0);
        chk("rlw_addr_async", mem_addr_o, 32'd0);
        chk("rlw_stall_async", {31'd0, stall_req_o}, 32'd0);
        chk("rlw_wdata", wdata_o, 32'd0);
        chk("rlw_wreg", {31'd0, wreg_o}, 32'd0);
        chk("rlw_wd", {27'd0, wd_o}, 32'd0);
        $display("txn reset_mid_lw: mem_req_o=%0d mem_addr_o=0x%08h", mem_req_o, mem_addr_o);
        @(negedge clk);
        rst = 1'b1;

        do_mem("sb_after_rst", EX_SB, 32'h0000_3000, 32'h1234_565A, 5'd4, 1'b1, 32'h0, 0, 0, 32'h0);
        do_alu("add3", 32'h0BAD_F00D, 5'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
